// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared register-bus types, write-enable/zero constants and load funct3 codes.
package wb_arbiter_pkg;
   typedef logic [31:0] RegBus;
   typedef logic [4:0]  RegAddrBus;
   localparam logic       WriteEnable = 1'b1;
   localparam RegBus      ZeroWord    = 32'h0000_0000;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_arbiter_load_extend.sv
// load_extend: selects the addressed byte/halfword of an aligned load word and sign/zero extends it.
module load_extend
   import wb_arbiter_pkg::*;
(
   input  logic [31:0] ld_raw,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   output logic [31:0] ld_data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = ld_raw[{ld_offset, 3'b000} +: 8];
      h = ld_offset[1] ? ld_raw[31:16] : ld_raw[15:0];
      ld_data = (ld_funct3 == F3_LB)  ? {{24{b[7]}}, b}  :
                (ld_funct3 == F3_LBU) ? {24'h0, b}       :
                (ld_funct3 == F3_LH)  ? {{16{h[15]}}, h} :
                (ld_funct3 == F3_LHU) ? {16'h0, h}       : ld_raw;
   end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin ALU/load writeback arbiter driving the register file write port,
// plus a pending-write scoreboard for decode-stage RAW hazard detection.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int REG_W  = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [REG_W-1:0]  alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [REG_W-1:0]  ld_raw,
   input  logic [2:0]        ld_funct3,
   input  logic [1:0]        ld_offset,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              we,
   output logic [REG_AW-1:0] waddr,
   output logic [REG_W-1:0]  wdata,
   output logic [31:0]       pending
);
   logic              last_ld_q, last_ld_d, we_q, we_d, xfer;
   logic [REG_AW-1:0] waddr_q, waddr_d, sel_rd;
   logic [REG_W-1:0]  wdata_q, wdata_d, sel_data, ld_data;
   logic [31:0]       pending_q, pending_d;
   load_extend u_load_extend (
      .ld_raw   (ld_raw),
      .ld_funct3(ld_funct3),
      .ld_offset(ld_offset),
      .ld_data  (ld_data)
   );
   always_comb begin
      alu_ready = !rst && rdy && alu_valid && (!ld_valid || last_ld_q);
      ld_ready  = !rst && rdy && ld_valid && (!alu_valid || !last_ld_q);
      xfer      = alu_ready || ld_ready;
      sel_rd    = ld_ready ? ld_rd : alu_rd;
      sel_data  = ld_ready ? ld_data : alu_data;
      last_ld_d = xfer ? ld_ready : last_ld_q;
      we_d      = (xfer && sel_rd != '0) ? WriteEnable : 1'b0;
      waddr_d   = we_d ? sel_rd : waddr_q;
      wdata_d   = we_d ? sel_data : wdata_q;
   end
   // A fresh issue to the register being committed this edge must stay pending.
   always_comb begin
      pending_d = pending_q;
      if (we_q) pending_d[waddr_q] = 1'b0;
      if (iss_valid && iss_rd != '0) pending_d[iss_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         last_ld_q <= 1'b1;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= ZeroWord;
         pending_q <= '0;
      end else if (rdy) begin
         last_ld_q <= last_ld_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         pending_q <= pending_d;
      end
   end
   assign we      = we_q;
   assign waddr   = waddr_q;
   assign wdata   = wdata_q;
   assign pending = pending_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed plus randomized checks of wb_arbiter against a behavioural model.
module tb_wb_arbiter;
   logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
   logic        alu_valid = 1'b0, ld_valid = 1'b0, iss_valid = 1'b0;
   logic        alu_ready, ld_ready, we;
   logic [4:0]  alu_rd = '0, ld_rd = '0, iss_rd = '0, waddr;
   logic [31:0] alu_data = '0, ld_raw = '0, wdata, pending;
   logic [2:0]  ld_funct3 = '0;
   logic [1:0]  ld_offset = '0;
   int          total = 0, bad = 0;
   logic        m_ok = 1'b0, m_last_ld, m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata, m_pend;
   logic        a_acc, l_acc;

   wb_arbiter #(.REG_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_raw(ld_raw),
      .ld_funct3(ld_funct3), .ld_offset(ld_offset),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .we(we), .waddr(waddr), .wdata(wdata), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // 0 = nobody, 1 = ALU, 2 = load
   function automatic int grant();
      if (rst || !rdy) return 0;
      if (alu_valid && ld_valid) return m_last_ld ? 1 : 2;
      if (alu_valid) return 1;
      if (ld_valid) return 2;
      return 0;
   endfunction

   function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [2:0] f3, input logic [1:0] off);
      longint v;
      case (f3)
         3'd0, 3'd4: begin
            v = (raw >> (8 * off)) & 255;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
         end
         3'd1, 3'd5: begin
            v = (raw >> (16 * (off / 2))) & 65535;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
         end
         default: v = raw;
      endcase
      return v[31:0];
   endfunction

   always @(posedge clk) begin
      int g;
      if (rst) begin
         m_ok = 1'b1; m_last_ld = 1'b1; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_pend = '0;
      end else if (m_ok && rdy) begin
         g = grant();
         if (m_we) m_pend[m_waddr] = 1'b0;
         if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
         m_we = 1'b0;
         if (g != 0) begin
            m_last_ld = (g == 2);
            if ((g == 1 ? alu_rd : ld_rd) != 0) begin
               m_we = 1'b1;
               m_waddr = g == 1 ? alu_rd : ld_rd;
               m_wdata = g == 1 ? alu_data : fmt(ld_raw, ld_funct3, ld_offset);
            end
         end
      end
   end

   always @(negedge clk) begin
      int g;
      if (m_ok) begin
         g = grant();
         chk("alu_ready", {31'd0, alu_ready}, {31'd0, g == 1});
         chk("ld_ready", {31'd0, ld_ready}, {31'd0, g == 2});
         chk("we", {31'd0, we}, {31'd0, m_we});
         if (m_we) begin
            chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
            chk("wdata", wdata, m_wdata);
         end
         chk("pending", pending, m_pend);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [31:0] raw_c = 32'h80FF_7F01;
   logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
   logic [1:0]  offs[6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
   logic [31:0] exps[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                            32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};

   initial begin
      #1;
      do_reset();
      @(negedge clk);
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_waddr", {27'd0, waddr}, 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_pending", pending, 32'd0);
      step();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
      @(negedge clk);
      chk("alu_ready_first", {31'd0, alu_ready}, 32'd1);
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      chk("alu_we", {31'd0, we}, 32'd1);
      chk("alu_waddr", {27'd0, waddr}, 32'd5);
      chk("alu_wdata", wdata, 32'h1234_5678);
      step();
      @(negedge clk);
      chk("alu_we_drop", {31'd0, we}, 32'd0);
      step();
      for (int i = 0; i < 6; i++) begin
         ld_valid = 1'b1; ld_rd = 5'd1; ld_raw = raw_c; ld_funct3 = f3s[i]; ld_offset = offs[i];
         @(negedge clk);
         chk("fmt_ld_ready", {31'd0, ld_ready}, 32'd1);
         step();
         ld_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("fmt_wdata_%0d", i), wdata, exps[i]);
         step();
      end
      do_reset();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("rr_alu_%0d", k), {31'd0, alu_ready}, {31'd0, k % 2 == 0});
         chk($sformatf("rr_ld_%0d", k), {31'd0, ld_ready}, {31'd0, k % 2 == 1});
         step();
      end
      alu_valid = 1'b0; ld_valid = 1'b0;
      step();
      step();
      iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      iss_valid = 1'b0;
      @(negedge clk);
      chk("sb_set7", {31'd0, pending[7]}, 32'd1);
      step();
      step();
      ld_valid = 1'b1; ld_rd = 5'd7; ld_raw = 32'h55; ld_funct3 = 3'b010;
      @(negedge clk);
      chk("sb_ld7_ready", {31'd0, ld_ready}, 32'd1);
      step();
      ld_valid = 1'b0;
      @(negedge clk);
      chk("sb_hold7", {31'd0, pending[7]}, 32'd1);
      step();
      @(negedge clk);
      chk("sb_clr7", {31'd0, pending[7]}, 32'd0);
      step();
      iss_valid = 1'b1; iss_rd = 5'd9;
      step();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      step();
      alu_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd9;
      @(negedge clk);
      chk("sb_commit9_we", {31'd0, we}, 32'd1);
      step();
      iss_valid = 1'b0;
      @(negedge clk);
      chk("sb_keep9", {31'd0, pending[9]}, 32'd1);
      step();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
      @(negedge clk);
      chk("rd0_ready", {31'd0, alu_ready}, 32'd1);
      step();
      alu_valid = 1'b0;
      @(negedge clk);
      chk("rd0_we", {31'd0, we}, 32'd0);
      chk("rd0_pend0", {31'd0, pending[0]}, 32'd0);
      step();
      alu_valid = 1'b1; alu_rd = 5'd2; ld_valid = 1'b1; ld_rd = 5'd6; rdy = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("pause_alu_ready", {31'd0, alu_ready}, 32'd0);
         chk("pause_ld_ready", {31'd0, ld_ready}, 32'd0);
         chk("pause_pend11", {31'd0, pending[11]}, 32'd0);
         step();
      end
      rdy = 1'b1; iss_valid = 1'b0;
      @(negedge clk);
      chk("resume_ld", {31'd0, ld_ready}, 32'd1);
      chk("resume_alu", {31'd0, alu_ready}, 32'd0);
      step();
      alu_valid = 1'b0; ld_valid = 1'b0;
      step();
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hCAFE;
      step();
      alu_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("pre_rst_we", {31'd0, we}, 32'd1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_we", {31'd0, we}, 32'd0);
      chk("post_rst_waddr", {27'd0, waddr}, 32'd0);
      chk("post_rst_wdata", wdata, 32'd0);
      chk("post_rst_pending", pending, 32'd0);
      step();
      a_acc = 1'b0; l_acc = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rdy = ($urandom % 8) != 0;
         rst = ($urandom % 250) == 0;
         iss_valid = ($urandom % 2) != 0;
         iss_rd = 5'($urandom_range(0, 9));
         if (!alu_valid || a_acc) begin
            alu_valid = ($urandom % 3) != 0;
            alu_rd = 5'($urandom_range(0, 9));
            alu_data = $urandom;
         end
         if (!ld_valid || l_acc) begin
            ld_valid = ($urandom % 3) != 0;
            ld_rd = 5'($urandom_range(0, 9));
            ld_raw = $urandom;
            ld_funct3 = 3'($urandom_range(0, 7));
            ld_offset = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         a_acc = alu_ready;
         l_acc = ld_ready;
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-side driver of the register file's single write port. Arbitrates between two result producers, the ALU path and the load path, formats load data (byte/halfword select plus sign/zero extension), and issues one registered write per cycle on `we`/`waddr`/`wdata`. It also keeps a 32-bit pending-write scoreboard that the decode stage uses to detect RAW hazards on results still in flight.

## Interface
Parameters:
- `REG_W`, 32: register data width.
- `REG_AW`, 5: register address width (32 registers).

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `rdy` input 1: global run enable; low means pause.
- `alu_valid` input 1: ALU result offered.
- `alu_ready` output 1: ALU result accepted this cycle.
- `alu_rd` input REG_AW: ALU destination register.
- `alu_data` input REG_W: ALU result.
- `ld_valid` input 1: load result offered.
- `ld_ready` output 1: load result accepted this cycle.
- `ld_rd` input REG_AW: load destination register.
- `ld_raw` input REG_W: aligned memory word.
- `ld_funct3` input 3: load type.
- `ld_offset` input 2: byte address [1:0].
- `iss_valid` input 1: an instruction with a destination register issued.
- `iss_rd` input REG_AW: destination of the issued instruction.
- `we` output 1: register file write enable.
- `waddr` output REG_AW: write address.
- `wdata` output REG_W: write data.
- `pending` output 32: bit i set means a write to register i is outstanding.

## Operation
- Handshake: a transfer occurs when valid && ready. `*_ready` is combinational from the valids, `rdy`, and the round-robin state, and does not depend on the other producer's data. At most one transfer per cycle.
- Arbitration:
  - Only one valid: that producer is granted.
  - Both valid: grant the producer not granted last. The `last_ld` flag updates only on a transfer.
- `rdy` low: both readies are 0; all state (outputs, `last_ld`, `pending`) holds; `iss_valid` is ignored.
- Load formatting, combinational:
  - funct3 000 LB: byte `ld_offset` sign-extended.
  - 001 LH: halfword `ld_offset[1]` sign-extended; `ld_offset[0]` ignored.
  - 010 LW: full word.
  - 100 LBU: byte zero-extended.
  - 101 LHU: halfword zero-extended.
  - Any other code: full word, unchanged.
- Output register, loaded every cycle while `rdy` is high:
  - On a transfer with rd != 0: `we`=1, `waddr`=rd, `wdata`=formatted data.
  - On a transfer with rd == 0: consumed, `we`=0.
  - No transfer: `we`=0; `waddr`/`wdata` keep their previous values.
- Scoreboard, updated at each edge while `rdy` is high:
  - Clear bit `waddr` if `we` is currently 1.
  - Then set bit `iss_rd` if `iss_valid` and `iss_rd` != 0. If set and clear hit the same index, set wins.
  - Bit 0 is always 0.
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `pending`=0, `last_ld`=1 (ALU wins the first tie). Readies are 0 while `rst` is high. A reset mid-operation drops any registered write and clears all pending bits.

## Timing
- Transfer in cycle N: `we`/`waddr`/`wdata` valid during cycle N+1, for exactly one cycle. The register file commits at the edge ending N+1.
- `pending[rd]` reads 0 from cycle N+2. During N+1 the register file's write-through bypass supplies the value.
- Issue in cycle M: `pending[iss_rd]` reads 1 from cycle M+1.
- Sustained throughput is one write per cycle. Under continuous contention, ALU and load strictly alternate.
- A producer's valid must stay high with stable data until ready. Dropping valid early is a protocol violation and is not checked.

## Structure
- Shared defines file holds `RegBus`, `RegAddrBus`, `WriteEnable`, `ZeroWord`, and the load funct3 codes (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
- One combinational sub-module, `load_extend` (inputs `ld_raw`, `ld_funct3`, `ld_offset`; output formatted word), instantiated once.
- The arbiter, output register, and scoreboard stay in `wb_arbiter`.

## Test plan
- Reset then single ALU transfer, rd=5, data 0x1234_5678: `alu_ready`=1 the same cycle; next cycle `we`=1, `waddr`=5, `wdata`=0x1234_5678; the following cycle `we`=0.
- Load formatting with `ld_raw`=0x80FF_7F01:
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
  - funct3 011 → 0x80FF_7F01.
- Both valid held 4 cycles after reset: grant order ALU, load, ALU, load; exactly one ready high per cycle.
- Scoreboard:
  - `iss_valid` rd=7 at cycle M → `pending[7]`=1 at M+1.
  - Load rd=7 transfers at M+3 → `pending[7]`=0 at M+5.
  - Issue rd=9 while the write to 9 commits → `pending[9]` stays 1.
- rd=0 and `rdy` low:
  - Transfer with rd=0 is accepted with `we`=0 and `pending[0]` stays 0.
  - `rdy` low for 3 cycles with both valid: readies 0, outputs and `pending` frozen, then resume correctly.
- `rst` asserted the cycle after a transfer: next cycle `we`=0, `waddr`=0, `wdata`=0, `pending`=0.
